// File: rtl/lcd_decoder_pkg.sv
// Shared constants, types and instruction decode for the two-chip LCD bus decoder.
package lcd_decoder_pkg;

  localparam int unsigned LCD_DATA_BIT_WIDTH   = 8;
  localparam int unsigned LCD_COL_SELECT_COUNT = 2;

  localparam logic LCD_INSTRUCTION = 1'b0;
  localparam logic LCD_DATA        = 1'b1;
  localparam logic LCD_WRITE       = 1'b0;

  localparam int unsigned LCD_STATUS_BUSY_BIT  = 7;
  localparam int unsigned LCD_STATUS_OFF_BIT   = 5;
  localparam int unsigned LCD_STATUS_RESET_BIT = 4;
  localparam int unsigned LCD_ADDR_Y_WRAP      = 64;

  typedef enum logic [2:0] {
    OpInvalid,
    OpOnOff,
    OpSetY,
    OpSetX,
    OpSetStart
  } inst_op_e;

  typedef struct packed {
    logic       chip;
    logic [2:0] page;
    logic [5:0] col;
    logic [7:0] data;
  } fb_wr_t;

  function automatic inst_op_e decode_inst(input logic [7:0] b);
    if (b[7:1] == 7'b0011111) begin
      return OpOnOff;
    end else if (b[7:6] == 2'b01) begin
      return OpSetY;
    end else if (b[7:3] == 5'b10111) begin
      return OpSetX;
    end else if (b[7:6] == 2'b11) begin
      return OpSetStart;
    end
    return OpInvalid;
  endfunction

endpackage

// File: rtl/lcd_decoder_if.sv
// Two-chip graphic LCD bus as seen between encoder (master) and panel (slave).
interface lcd_decoder_if;
  import lcd_decoder_pkg::*;

  logic [LCD_DATA_BIT_WIDTH-1:0]   data;
  logic [LCD_COL_SELECT_COUNT-1:0] cs;
  logic                            io;
  logic                            wr;
  logic                            en;
  logic                            reset_n;

  modport master (output data, cs, io, wr, en, reset_n);
  modport slave  (input data, cs, io, wr, en, reset_n);
endinterface

// File: rtl/lcd_decoder_chip.sv
// Per-chip controller state: Y/X/start/on registers, instruction apply and busy countdown.
module lcd_decoder_chip
  import lcd_decoder_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 4
) (
  input  logic       clk_lcd,
  input  logic       reset,
  input  logic       panel_reset,
  input  logic       inst_we,
  input  logic [7:0] inst_byte,
  input  logic       data_we,
  input  logic       load_busy,
  output logic [5:0] y,
  output logic [2:0] x,
  output logic [5:0] start,
  output logic       on,
  output logic       busy
);

  localparam int unsigned CntW = (BUSY_CYCLES < 1) ? 1 : $clog2(BUSY_CYCLES + 1);

  logic [5:0]      y_q, y_d;
  logic [2:0]      x_q, x_d;
  logic [5:0]      start_q, start_d;
  logic            on_q, on_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  inst_op_e        op;

  assign op = decode_inst(inst_byte);

  always_comb begin
    y_d     = y_q;
    x_d     = x_q;
    start_d = start_q;
    on_d    = on_q;
    if (inst_we) begin
      case (op)
        OpOnOff:    on_d    = inst_byte[0];
        OpSetY:     y_d     = inst_byte[5:0];
        OpSetX:     x_d     = inst_byte[2:0];
        OpSetStart: start_d = inst_byte[5:0];
        default:    ;
      endcase
    end else if (data_we) begin
      // Column auto-increments after each data write; page is left alone.
      y_d = (y_q == 6'(LCD_ADDR_Y_WRAP - 1)) ? '0 : y_q + 6'd1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_busy) begin
      cnt_d = CntW'(BUSY_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_lcd) begin
    if (reset) begin
      y_q     <= '0;
      x_q     <= '0;
      start_q <= '0;
      on_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (panel_reset) begin
      y_q     <= '0;
      x_q     <= '0;
      start_q <= '0;
      on_q    <= 1'b0;
      cnt_q   <= cnt_d;
    end else begin
      y_q     <= y_d;
      x_q     <= x_d;
      start_q <= start_d;
      on_q    <= on_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y     = y_q;
  assign x     = x_q;
  assign start = start_q;
  assign on    = on_q;
  assign busy  = (cnt_q != '0);

endmodule

// File: rtl/lcd_decoder.sv
// Panel-side LCD bus decoder: captures the bus, decodes each lcd_en fall into chip state
// updates and a serialised stream of frame-memory writes.
module lcd_decoder
  import lcd_decoder_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 4
) (
  input  logic                clk_lcd,
  input  logic                reset,
  lcd_decoder_if.slave        bus,
  output logic [7:0]          status_data,
  output logic                fb_we,
  output logic                fb_chip,
  output logic [2:0]          fb_page,
  output logic [5:0]          fb_col,
  output logic [7:0]          fb_data,
  output logic [1:0]          display_on,
  output logic [11:0]         start_line,
  output logic                err,
  input  logic                err_clear
);

  localparam int unsigned FifoDepth = 3;

  logic       en_q;
  logic [7:0] cap_data_q;
  logic [1:0] cap_cs_q;
  logic       cap_io_q;
  logic       cap_wr_q;

  logic fall, dec, is_wr, inst_we, data_we, data_rd, inst_err, overrun, ovf;

  logic [5:0] chip_y     [2];
  logic [2:0] chip_x     [2];
  logic [5:0] chip_start [2];
  logic [1:0] chip_on;
  logic [1:0] chip_busy;

  fb_wr_t     fifo_q [FifoDepth];
  fb_wr_t     fifo_d [FifoDepth];
  logic [1:0] fifo_cnt_q, fifo_cnt_d;
  fb_wr_t     cand   [8];
  logic [2:0] cand_n;
  fb_wr_t     fb_q, fb_d;
  logic       fb_we_q, fb_we_d;
  logic       err_q, err_d;
  logic [7:0] status_q, status_d;
  logic       sel;

  always_ff @(posedge clk_lcd) begin
    if (reset) begin
      en_q       <= 1'b0;
      cap_data_q <= '0;
      cap_cs_q   <= '0;
      cap_io_q   <= 1'b0;
      cap_wr_q   <= 1'b0;
    end else begin
      en_q <= bus.en;
      if (bus.en) begin
        cap_data_q <= bus.data;
        cap_cs_q   <= bus.cs;
        cap_io_q   <= bus.io;
        cap_wr_q   <= bus.wr;
      end
    end
  end

  // Falls are decoded from the captured bus only; the live bus may already have moved on.
  assign fall     = en_q & ~bus.en;
  assign dec      = fall & bus.reset_n & (cap_cs_q != '0);
  assign is_wr    = (cap_wr_q == LCD_WRITE);
  assign inst_we  = dec & is_wr & (cap_io_q == LCD_INSTRUCTION);
  assign data_we  = dec & is_wr & (cap_io_q == LCD_DATA);
  assign data_rd  = dec & ~is_wr & (cap_io_q == LCD_DATA);
  assign inst_err = inst_we & (decode_inst(cap_data_q) == OpInvalid);
  assign overrun  = (inst_we | data_we) & ((fifo_cnt_q != '0) | ((cap_cs_q & chip_busy) != '0));

  for (genvar i = 0; i < 2; i++) begin : g_chip
    lcd_decoder_chip #(
      .BUSY_CYCLES (BUSY_CYCLES)
    ) u_chip (
      .clk_lcd     (clk_lcd),
      .reset       (reset),
      .panel_reset (~bus.reset_n),
      .inst_we     (inst_we & cap_cs_q[i]),
      .inst_byte   (cap_data_q),
      .data_we     (data_we & cap_cs_q[i]),
      .load_busy   ((inst_we | data_we) & cap_cs_q[i]),
      .y           (chip_y[i]),
      .x           (chip_x[i]),
      .start       (chip_start[i]),
      .on          (chip_on[i]),
      .busy        (chip_busy[i])
    );
  end

  // Queued writes go out first, then the new ones in chip order, one per cycle.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cand[i] = '0;
    end
    for (int i = 0; i < FifoDepth; i++) begin
      cand[i] = fifo_q[i];
    end
    cand_n = {1'b0, fifo_cnt_q};
    if (data_we && cap_cs_q[0]) begin
      cand[cand_n] = '{chip: 1'b0, page: chip_x[0], col: chip_y[0], data: cap_data_q};
      cand_n       = cand_n + 3'd1;
    end
    if (data_we && cap_cs_q[1]) begin
      cand[cand_n] = '{chip: 1'b1, page: chip_x[1], col: chip_y[1], data: cap_data_q};
      cand_n       = cand_n + 3'd1;
    end
    fb_d    = cand[0];
    fb_we_d = (cand_n != '0);
    for (int i = 0; i < FifoDepth; i++) begin
      fifo_d[i] = cand[i+1];
    end
    ovf = 1'b0;
    if (cand_n == '0) begin
      fifo_cnt_d = '0;
    end else if (cand_n > 3'(FifoDepth + 1)) begin
      fifo_cnt_d = 2'(FifoDepth);
      ovf        = 1'b1;
    end else begin
      fifo_cnt_d = 2'(cand_n - 3'd1);
    end
  end

  assign err_d = (err_q & ~err_clear) | inst_err | data_rd | overrun | ovf;
  assign sel   = ~bus.cs[0];

  always_comb begin
    status_d = status_q;
    if (bus.en && (bus.wr != LCD_WRITE)) begin
      status_d = '0;
      if ((bus.io == LCD_INSTRUCTION) && (bus.cs != '0)) begin
        status_d[LCD_STATUS_BUSY_BIT]  = chip_busy[sel] | ~bus.reset_n;
        status_d[LCD_STATUS_OFF_BIT]   = ~chip_on[sel];
        status_d[LCD_STATUS_RESET_BIT] = ~bus.reset_n;
      end
    end
  end

  always_ff @(posedge clk_lcd) begin
    if (reset) begin
      for (int i = 0; i < FifoDepth; i++) begin
        fifo_q[i] <= '0;
      end
      fifo_cnt_q <= '0;
      fb_q       <= '0;
      fb_we_q    <= 1'b0;
      err_q      <= 1'b0;
      status_q   <= '0;
    end else begin
      for (int i = 0; i < FifoDepth; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
      fifo_cnt_q <= fifo_cnt_d;
      fb_q       <= fb_d;
      fb_we_q    <= fb_we_d;
      err_q      <= err_d;
      status_q   <= status_d;
    end
  end

  assign status_data = status_q;
  assign fb_we       = fb_we_q;
  assign fb_chip     = fb_q.chip;
  assign fb_page     = fb_q.page;
  assign fb_col      = fb_q.col;
  assign fb_data     = fb_q.data;
  assign display_on  = chip_on;
  assign start_line  = {chip_start[1], chip_start[0]};
  assign err         = err_q;

endmodule

// File: tb/tb_lcd_decoder.sv
// Directed bench for lcd_decoder: drives the LCD bus and checks decoded state and fb writes.
module tb_lcd_decoder;
  import lcd_decoder_pkg::*;

  logic        clk_lcd = 1'b0;
  logic        reset;
  logic        err_clear;
  logic [7:0]  status_data;
  logic        fb_we, fb_chip, err;
  logic [2:0]  fb_page;
  logic [5:0]  fb_col;
  logic [7:0]  fb_data;
  logic [1:0]  display_on;
  logic [11:0] start_line;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_decoder_if bus ();

  lcd_decoder #(
    .BUSY_CYCLES (4)
  ) dut (
    .clk_lcd     (clk_lcd),
    .reset       (reset),
    .bus         (bus),
    .status_data (status_data),
    .fb_we       (fb_we),
    .fb_chip     (fb_chip),
    .fb_page     (fb_page),
    .fb_col      (fb_col),
    .fb_data     (fb_data),
    .display_on  (display_on),
    .start_line  (start_line),
    .err         (err),
    .err_clear   (err_clear)
  );

  always #5 clk_lcd = ~clk_lcd;

  task automatic idle(input int n);
    repeat (n) @(negedge clk_lcd);
  endtask

  // en high across one rising edge, then low: the fall is decoded on the next rising edge.
  task automatic bus_write(input logic io, input logic [1:0] cs, input logic [7:0] d);
    bus.io   = io;
    bus.wr   = LCD_WRITE;
    bus.cs   = cs;
    bus.data = d;
    bus.en   = 1'b1;
    @(negedge clk_lcd);
    bus.en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    n_checks++;
    if ({status_data, fb_we, display_on, start_line, err} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {status_data, fb_we, display_on, start_line, err});
    end
    n_checks++;
    if ({fb_chip, fb_page, fb_col, fb_data} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_fb: got %h want 0", {fb_chip, fb_page, fb_col, fb_data});
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_display_on;
    bus.reset_n = 1'b0;
    idle(3);
    bus.reset_n = 1'b1;
    idle(1);
    bus_write(LCD_INSTRUCTION, 2'b11, 8'h3F);
    @(negedge clk_lcd);
    n_checks++;
    if (display_on !== 2'b11) begin
      n_fail++;
      $display("FAIL display_on: got %b want 11", display_on);
    end
    bus.wr = 1'b1;
    bus.io = LCD_INSTRUCTION;
    bus.cs = 2'b01;
    bus.en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_lcd);
      n_checks++;
      if (status_data !== ((i < 4) ? 8'h80 : 8'h00)) begin
        n_fail++;
        $display("FAIL status_busy[%0d]: got %h want %h", i, status_data,
                 (i < 4) ? 8'h80 : 8'h00);
      end
    end
    bus.en = 1'b0;
    idle(5);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL status_read_err: got %b want 0", err);
    end
  endtask

  task automatic test_data_write;
    bus_write(LCD_INSTRUCTION, 2'b01, 8'hB8);
    idle(5);
    bus_write(LCD_INSTRUCTION, 2'b01, 8'h40);
    idle(5);
    bus_write(LCD_DATA, 2'b01, 8'hFF);
    @(negedge clk_lcd);
    n_checks++;
    if ({fb_we, fb_chip, fb_page, fb_col, fb_data} !== {1'b1, 1'b0, 3'd0, 6'd0, 8'hFF}) begin
      n_fail++;
      $display("FAIL data_write: got we=%b chip=%0d page=%0d col=%0d data=%h want 1/0/0/0/ff",
               fb_we, fb_chip, fb_page, fb_col, fb_data);
    end
    @(negedge clk_lcd);
    n_checks++;
    if (fb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL data_write_single: got fb_we=%b want 0", fb_we);
    end
    idle(4);
    bus_write(LCD_DATA, 2'b01, 8'h11);
    @(negedge clk_lcd);
    n_checks++;
    if ({fb_we, fb_col, fb_data} !== {1'b1, 6'd1, 8'h11}) begin
      n_fail++;
      $display("FAIL y_increment: got we=%b col=%0d data=%h want 1/1/11", fb_we, fb_col, fb_data);
    end
    idle(5);
  endtask

  task automatic test_wrap;
    bus_write(LCD_INSTRUCTION, 2'b01, 8'h7F);
    idle(5);
    bus_write(LCD_DATA, 2'b01, 8'h01);
    @(negedge clk_lcd);
    n_checks++;
    if ({fb_we, fb_page, fb_col, fb_data} !== {1'b1, 3'd0, 6'd63, 8'h01}) begin
      n_fail++;
      $display("FAIL wrap_col63: got we=%b page=%0d col=%0d data=%h want 1/0/63/01",
               fb_we, fb_page, fb_col, fb_data);
    end
    idle(5);
    bus_write(LCD_DATA, 2'b01, 8'h03);
    @(negedge clk_lcd);
    n_checks++;
    if ({fb_we, fb_page, fb_col, fb_data} !== {1'b1, 3'd0, 6'd0, 8'h03}) begin
      n_fail++;
      $display("FAIL wrap_col0: got we=%b page=%0d col=%0d data=%h want 1/0/0/03",
               fb_we, fb_page, fb_col, fb_data);
    end
    idle(5);
  endtask

  task automatic test_both_chips;
    bus_write(LCD_INSTRUCTION, 2'b01, 8'h45);
    idle(5);
    bus_write(LCD_INSTRUCTION, 2'b10, 8'h49);
    idle(5);
    bus_write(LCD_DATA, 2'b11, 8'hA5);
    @(negedge clk_lcd);
    n_checks++;
    if ({fb_we, fb_chip, fb_page, fb_col, fb_data} !== {1'b1, 1'b0, 3'd0, 6'd5, 8'hA5}) begin
      n_fail++;
      $display("FAIL both_chip0: got we=%b chip=%0d col=%0d data=%h want 1/0/5/a5",
               fb_we, fb_chip, fb_col, fb_data);
    end
    @(negedge clk_lcd);
    n_checks++;
    if ({fb_we, fb_chip, fb_page, fb_col, fb_data} !== {1'b1, 1'b1, 3'd0, 6'd9, 8'hA5}) begin
      n_fail++;
      $display("FAIL both_chip1: got we=%b chip=%0d col=%0d data=%h want 1/1/9/a5",
               fb_we, fb_chip, fb_col, fb_data);
    end
    @(negedge clk_lcd);
    n_checks++;
    if ({fb_we, err} !== 2'b00) begin
      n_fail++;
      $display("FAIL both_done: got we=%b err=%b want 0/0", fb_we, err);
    end
    idle(4);
  endtask

  task automatic test_start_err;
    bus_write(LCD_INSTRUCTION, 2'b10, 8'hF8);
    @(negedge clk_lcd);
    n_checks++;
    if (start_line !== {6'd56, 6'd0}) begin
      n_fail++;
      $display("FAIL start_line: got %h want %h", start_line, {6'd56, 6'd0});
    end
    idle(5);
    bus_write(LCD_INSTRUCTION, 2'b01, 8'h20);
    @(negedge clk_lcd);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_inst_err: got %b want 1", err);
    end
    err_clear = 1'b1;
    @(negedge clk_lcd);
    err_clear = 1'b0;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b want 0", err);
    end
    idle(5);
  endtask

  task automatic test_back_to_back;
    bus_write(LCD_DATA, 2'b01, 8'h5A);
    @(negedge clk_lcd);
    n_checks++;
    if ({fb_we, fb_col, fb_data, err} !== {1'b1, 6'd6, 8'h5A, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_first: got we=%b col=%0d data=%h err=%b want 1/6/5a/0",
               fb_we, fb_col, fb_data, err);
    end
    bus_write(LCD_DATA, 2'b01, 8'h6B);
    @(negedge clk_lcd);
    n_checks++;
    if ({fb_we, fb_col, fb_data, err} !== {1'b1, 6'd7, 8'h6B, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_overrun: got we=%b col=%0d data=%h err=%b want 1/7/6b/1",
               fb_we, fb_col, fb_data, err);
    end
    err_clear = 1'b1;
    @(negedge clk_lcd);
    err_clear = 1'b0;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_clear: got %b want 0", err);
    end
    idle(5);
  endtask

  task automatic test_panel_reset;
    bus.reset_n = 1'b0;
    @(negedge clk_lcd);
    n_checks++;
    if ({display_on, start_line} !== 14'h0) begin
      n_fail++;
      $display("FAIL panel_reset_state: got on=%b start=%h want 0/0", display_on, start_line);
    end
    bus.wr = 1'b1;
    bus.io = LCD_INSTRUCTION;
    bus.cs = 2'b01;
    bus.en = 1'b1;
    @(negedge clk_lcd);
    n_checks++;
    if (status_data !== 8'hB0) begin
      n_fail++;
      $display("FAIL panel_reset_status: got %h want b0", status_data);
    end
    bus.en = 1'b0;
    @(negedge clk_lcd);
    bus_write(LCD_DATA, 2'b01, 8'h77);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_lcd);
      n_checks++;
      if (fb_we !== 1'b0) begin
        n_fail++;
        $display("FAIL panel_reset_fb[%0d]: got fb_we=%b want 0", i, fb_we);
      end
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL panel_reset_err: got %b want 0", err);
    end
    bus.reset_n = 1'b1;
    idle(3);
  endtask

  initial begin
    reset       = 1'b1;
    err_clear   = 1'b0;
    bus.data    = '0;
    bus.cs      = '0;
    bus.io      = LCD_INSTRUCTION;
    bus.wr      = LCD_WRITE;
    bus.en      = 1'b0;
    bus.reset_n = 1'b1;
    test_reset;
    test_display_on;
    test_data_write;
    test_wrap;
    test_both_chips;
    test_start_err;
    test_back_to_back;
    test_panel_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_decoder.md
Name: lcd_decoder

Overview:
- Panel-side counterpart of lcd_encoder. It samples the two-chip graphic LCD bus (lcd_data, lcd_cs, lcd_io, lcd_wr, lcd_en, lcd_reset_n) on clk_lcd and decodes each lcd_en falling edge into per-chip controller state updates and frame-memory write strobes.
- Used as a synthesizable panel model for closed-loop checking of the encoder.
- Also used as a front end for an on-chip framebuffer mirror.

Parameters:
- BUSY_CYCLES, 4, clk_lcd cycles that the status busy bit stays set after each accepted transfer.

Ports:
- clk_lcd  in  1  single clock; all logic samples on its rising edge.
- reset  in  1  synchronous, active-high reset.
- lcd_data  in  `LCD_DATA_BIT_WIDTH (8)  bus data byte.
- lcd_cs  in  `LCD_COL_SELECT_COUNT (2)  chip select; bit0 = left chip, bit1 = right chip.
- lcd_io  in  1  `LCD_INSTRUCTION or `LCD_DATA.
- lcd_wr  in  1  `LCD_WRITE or read.
- lcd_en  in  1  transfer strobe; decoded on its falling edge.
- lcd_reset_n  in  1  panel reset, active low.
- status_data  out  8  read-back status byte: {busy, 0, display_off, in_reset, 4'b0}, for the lowest selected chip.
- fb_we  out  1  one-cycle frame-memory write strobe.
- fb_chip  out  1  chip index of the write.
- fb_page  out  3  X address (page) of the write.
- fb_col  out  6  Y address (column) of the write.
- fb_data  out  8  byte written.
- display_on  out  2  per-chip display-on flag.
- start_line  out  12  {chip1[5:0], chip0[5:0]} display start lines.
- err  out  1  sticky error flag.
- err_clear  in  1  clears err.

Behaviour:
- Reset (reset=1): all outputs 0. Per-chip state: y=0, x=0, start=0, on=0, busy counter=0. Pending slot empty. en_q=0.
- Edge detect:
  - en_q registers lcd_en every cycle.
  - fall = en_q & ~lcd_en.
  - Bus fields are latched into cap_* on every cycle in which lcd_en=1. A fall always uses cap_* and never the live bus.
- Panel reset:
  - While lcd_reset_n=0, both chips are forced to on=0, start=0, y=0, x=0 and no transfers are decoded.
  - in_reset=1 and busy=1.
  - A fall during this time is ignored and does not set err.
- Instruction write (cap_io=`LCD_INSTRUCTION, cap_wr=`LCD_WRITE), applied in cycle N+1 to every selected chip (N = fall cycle):
  - 0011111b → on=b.
  - 01yyyyyy → y=yyyyyy.
  - 10111xxx → x=xxx.
  - 11ssssss → start=ssssss.
  - Any other byte → no state change; err=1.
- Data write (cap_io=`LCD_DATA):
  - First selected chip (lowest index): fb_we=1 at N+1 with that chip's x, y and cap_data; that chip's y increments mod 64 (63 wraps to 0; x is unchanged).
  - If both chips are selected, chip1's write is held in the pending slot and emitted at N+2, with the same y wrap rule.
- Read (cap_wr != `LCD_WRITE):
  - Status read drives status_data, which is stable from the cycle after lcd_en rises.
  - Data read is unsupported: status_data=0 and err=1.
- lcd_cs=2'b00 on a fall: no effect, no error.
- Busy: any accepted fall reloads each selected chip's counter to BUSY_CYCLES. The counter decrements to 0 each cycle, and busy = counter != 0.
- Overrun: a fall while the pending slot is occupied or the target chip is busy:
  - err=1.
  - The transfer is still decoded.
  - The pending write is emitted first; the new write is emitted the following cycle.
- err_clear and a new error in the same cycle: err stays 1.
- fb_we is never high for two chips in the same cycle.

Decomposition:
- Existing shared lcd.vh holds the bus-width, prefix, LCD_INSTRUCTION/LCD_DATA and LCD_WRITE constants. Add to it:
  - `LCD_STATUS_BUSY_BIT
  - `LCD_STATUS_OFF_BIT
  - `LCD_STATUS_RESET_BIT
  - `LCD_ADDR_Y_WRAP (64)
- One sub-module, lcd_decoder_chip, instantiated twice. It holds the y/x/start/on registers, instruction decode and the busy counter. The top module holds edge detect, capture, the pending slot and the fb mux.

Test Plan:
- lcd_reset_n=0 then 1, then instruction 0x3F with cs=2'b11 → display_on=2'b11 at N+1; status busy bit set for 4 cycles, then clear.
- Instructions 0xB8 and 0x40 with cs=01, then data 0xFF → fb_we at N+1 with chip0, page0, col0, data 0xFF; chip0 y becomes 1.
- Instruction 0x7F with cs=01, then two data writes 0x01 and 0x03 → cols 63 then 0 (wrap), page unchanged.
- Data 0xA5 with cs=11, y0=5, y1=9 → chip0 col5 at N+1 and chip1 col9 at N+2, both data 0xA5.
- Instruction 0xF8 with cs=10 → start_line[11:6]=56, start_line[5:0] unchanged. Then instruction 0x20 → err=1; err_clear → err=0.
- lcd_reset_n pulsed low mid-sequence with start=56 → start=0, on=0, in_reset status bit=1; a fall during reset produces no fb_we.
